// File: rtl/axis_packet_generator_pkg.sv
// ---------------------------------------------------------------------------
// axis_packet_generator_pkg
// Switch-wide constants shared by the synthetic frame source:
//   - EtherType values used in generated frames
//   - tuser side-band field offsets
//   - generator state encoding
//   - ceil_div helper for beat-count arithmetic
// ---------------------------------------------------------------------------
package axis_packet_generator_pkg;

    localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;
    localparam logic [15:0] ETH_TYPE_TEST = 16'h88B5;

    localparam int unsigned TUSER_LEN_LSB      = 0;
    localparam int unsigned TUSER_LEN_W        = 16;
    localparam int unsigned TUSER_SRC_PORT_LSB = 16;
    localparam int unsigned TUSER_SRC_PORT_W   = 8;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } gen_state_e;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/eth_frame_beat_builder.sv
// ---------------------------------------------------------------------------
// eth_frame_beat_builder
// Combinational: returns the tdata/tkeep of one beat of the test frame.
// Frame: DST MAC, SRC MAC, optional 802.1Q tag, EtherType 0x88B5,
// 32-bit sequence number (MSB first), then filler bytes 0,1,2,...
// Ports:
//   beat_idx  in  BEAT_W           beat number within the frame
//   seq_num   in  32               sequence number carried by the frame
//   tdata     out AXIS_DATA_WIDTH  byte n at [8n+7:8n]; bytes past the end are 0
//   tkeep     out AXIS_DATA_WIDTH/8 byte enables
// ---------------------------------------------------------------------------
module eth_frame_beat_builder
    import axis_packet_generator_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH = 256,
    parameter logic [47:0] DST_MAC_ADDR    = 48'h0,
    parameter logic [47:0] SRC_MAC_ADDR    = 48'h0,
    parameter logic        VLAN            = 1'b0,
    parameter logic [2:0]  PRI             = 3'b000,
    parameter logic [11:0] VID             = 12'd1,
    parameter int unsigned PKT_LEN         = 64,
    parameter int unsigned BEAT_W          = 16
) (
    input  logic [BEAT_W-1:0]            beat_idx,
    input  logic [31:0]                  seq_num,
    output logic [AXIS_DATA_WIDTH-1:0]   tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0] tkeep
);

    localparam int unsigned BYTES     = AXIS_DATA_WIDTH / 8;
    localparam int unsigned ETYPE_OFF = (VLAN != 1'b0) ? 16 : 12;
    localparam int unsigned FILL_OFF  = ETYPE_OFF + 6;
    localparam logic [31:0] TAG_WORD  = {ETH_TYPE_VLAN, PRI, 1'b0, VID};

    logic [31:0] beat_base;

    // Byte at absolute frame offset 'a'.
    function automatic logic [7:0] frame_byte(input int unsigned a, input logic [31:0] seq);
        logic [31:0] fill_idx;
        if (a < 6) begin
            return DST_MAC_ADDR[8*(5-a) +: 8];
        end
        if (a < 12) begin
            return SRC_MAC_ADDR[8*(11-a) +: 8];
        end
        if ((VLAN != 1'b0) && (a < 16)) begin
            return TAG_WORD[8*(15-a) +: 8];
        end
        if (a < ETYPE_OFF + 2) begin
            return ETH_TYPE_TEST[8*(ETYPE_OFF+1-a) +: 8];
        end
        if (a < FILL_OFF) begin
            return seq[8*(FILL_OFF-1-a) +: 8];
        end
        fill_idx = a - FILL_OFF;
        return fill_idx[7:0];
    endfunction

    assign beat_base = 32'(beat_idx) * BYTES;

    always_comb begin
        tdata = '0;
        tkeep = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (beat_base + b < PKT_LEN) begin
                tdata[8*b +: 8] = frame_byte(beat_base + b, seq_num);
                tkeep[b]        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_packet_generator.sv
// ---------------------------------------------------------------------------
// axis_packet_generator
// Synthetic Ethernet frame source driving one AXI4-Stream switch input.
// Sends back-to-back frames of PKT_LEN bytes separated by GAP_CYCLES idle
// cycles, starting START_DELAY cycles after reset release; stops after
// NUM_PKTS frames when NUM_PKTS is non-zero.
// Ports:
//   axis_aclk      in   clock
//   axis_resetn    in   asynchronous active-low reset
//   s_axis_tdata   out  frame data, byte n at [8n+7:8n]
//   s_axis_tkeep   out  byte enables
//   s_axis_tuser   out  {..0, 1<<SRC_PORT [23:16], PKT_LEN [15:0]}
//   s_axis_tvalid  out  beat valid
//   s_axis_tready  in   sink ready
//   s_axis_tlast   out  last beat of frame
// ---------------------------------------------------------------------------
module axis_packet_generator
    import axis_packet_generator_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH  = 256,
    parameter int unsigned AXIS_TUSER_WIDTH = 128,
    parameter logic [47:0] DST_MAC_ADDR     = 48'h0,
    parameter logic [47:0] SRC_MAC_ADDR     = 48'h0,
    parameter logic        VLAN             = 1'b0,
    parameter logic [2:0]  PRI              = 3'b000,
    parameter logic [11:0] VID              = 12'd1,
    parameter int unsigned SRC_PORT         = 0,
    parameter int unsigned PKT_LEN          = 64,
    parameter int unsigned GAP_CYCLES       = 4,
    parameter int unsigned START_DELAY      = 16,
    parameter int unsigned NUM_PKTS         = 0
) (
    input  logic                          axis_aclk,
    input  logic                          axis_resetn,
    output logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    output logic                          s_axis_tvalid,
    input  logic                          s_axis_tready,
    output logic                          s_axis_tlast
);

    localparam int unsigned BYTES       = AXIS_DATA_WIDTH / 8;
    localparam int unsigned BEATS       = ceil_div(PKT_LEN, BYTES);
    localparam int unsigned BEAT_W      = 16;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [31:0] START_LIMIT = 32'(START_DELAY);
    // The WAIT state is left on the edge that completes the last idle cycle,
    // so the inter-frame limit is one less than the gap; a zero gap never
    // enters WAIT at all.
    localparam logic [31:0] GAP_LIMIT   = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
    localparam logic [31:0] PKT_QUOTA   = 32'(NUM_PKTS);

    gen_state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        started_q, started_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [31:0] seq_q, seq_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;

    logic                         tvalid_q, tvalid_d;
    logic                         tlast_q, tlast_d;
    logic [AXIS_DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [BYTES-1:0]             tkeep_q, tkeep_d;
    logic [AXIS_TUSER_WIDTH-1:0]  tuser_q, tuser_d;

    logic                         load_beat;
    logic                         go_idle;
    logic [AXIS_DATA_WIDTH-1:0]   beat_tdata;
    logic [BYTES-1:0]             beat_tkeep;
    logic [AXIS_TUSER_WIDTH-1:0]  tuser_frame;

    always_comb begin
        tuser_frame = '0;
        tuser_frame[TUSER_LEN_LSB +: TUSER_LEN_W]           = 16'(PKT_LEN);
        tuser_frame[TUSER_SRC_PORT_LSB +: TUSER_SRC_PORT_W] = 8'd1 << SRC_PORT;
    end

    // Builder sees the next beat/sequence so its result lands in the output
    // registers on the same edge the FSM advances.
    eth_frame_beat_builder #(
        .AXIS_DATA_WIDTH (AXIS_DATA_WIDTH),
        .DST_MAC_ADDR    (DST_MAC_ADDR),
        .SRC_MAC_ADDR    (SRC_MAC_ADDR),
        .VLAN            (VLAN),
        .PRI             (PRI),
        .VID             (VID),
        .PKT_LEN         (PKT_LEN),
        .BEAT_W          (BEAT_W)
    ) u_beat_builder (
        .beat_idx (beat_d),
        .seq_num  (seq_d),
        .tdata    (beat_tdata),
        .tkeep    (beat_tkeep)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        started_d = started_q;
        beat_d    = beat_q;
        seq_d     = seq_q;
        pkt_cnt_d = pkt_cnt_q;
        load_beat = 1'b0;
        go_idle   = 1'b0;
        unique case (state_q)
            ST_WAIT: begin
                if (cnt_q >= (started_q ? GAP_LIMIT : START_LIMIT)) begin
                    state_d   = ST_SEND;
                    beat_d    = '0;
                    load_beat = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_SEND: begin
                if (tvalid_q && s_axis_tready) begin
                    if (tlast_q) begin
                        seq_d     = seq_q + 32'd1;
                        pkt_cnt_d = pkt_cnt_q + 32'd1;
                        beat_d    = '0;
                        if ((PKT_QUOTA != 32'd0) && (pkt_cnt_d == PKT_QUOTA)) begin
                            state_d = ST_DONE;
                            go_idle = 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            load_beat = 1'b1;
                        end else begin
                            state_d   = ST_WAIT;
                            cnt_d     = '0;
                            started_d = 1'b1;
                            go_idle   = 1'b1;
                        end
                    end else begin
                        beat_d    = beat_q + BEAT_W'(1);
                        load_beat = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    always_comb begin
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tuser_d  = tuser_q;
        if (load_beat) begin
            tvalid_d = 1'b1;
            tlast_d  = (beat_d == LAST_BEAT);
            tdata_d  = beat_tdata;
            tkeep_d  = beat_tkeep;
            tuser_d  = tuser_frame;
        end else if (go_idle) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
            tkeep_d  = '0;
            tuser_d  = '0;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q   <= ST_WAIT;
            cnt_q     <= '0;
            started_q <= 1'b0;
            beat_q    <= '0;
            seq_q     <= '0;
            pkt_cnt_q <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
            tkeep_q   <= '0;
            tuser_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            started_q <= started_d;
            beat_q    <= beat_d;
            seq_q     <= seq_d;
            pkt_cnt_q <= pkt_cnt_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tdata_q   <= tdata_d;
            tkeep_q   <= tkeep_d;
            tuser_q   <= tuser_d;
        end
    end

    assign s_axis_tvalid = tvalid_q;
    assign s_axis_tlast  = tlast_q;
    assign s_axis_tdata  = tdata_q;
    assign s_axis_tkeep  = tkeep_q;
    assign s_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_axis_packet_generator.sv
// ---------------------------------------------------------------------------
// tb_axis_packet_generator
// Two generator instances: A (no tag, 70-byte frames, unlimited) and
// B (802.1Q tag, 64-byte frames, quota of 3). Frames are rebuilt byte by
// byte from the frame format and compared beat by beat under random tready.
// ---------------------------------------------------------------------------
module tb_axis_packet_generator;

    localparam int unsigned DW = 256;
    localparam int unsigned UW = 128;
    localparam int unsigned NB = DW / 8;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [DW-1:0] tdata_a, tdata_b;
    logic [NB-1:0] tkeep_a, tkeep_b;
    logic [UW-1:0] tuser_a, tuser_b;
    logic          tvalid_a, tvalid_b, tlast_a, tlast_b;
    logic          tready_a, tready_b;

    axis_packet_generator #(
        .AXIS_DATA_WIDTH  (DW),
        .AXIS_TUSER_WIDTH (UW),
        .DST_MAC_ADDR     (48'h111111111111),
        .SRC_MAC_ADDR     (48'h020000000001),
        .VLAN             (1'b0),
        .PRI              (3'b000),
        .VID              (12'd1),
        .SRC_PORT         (0),
        .PKT_LEN          (70),
        .GAP_CYCLES       (4),
        .START_DELAY      (16),
        .NUM_PKTS         (0)
    ) dut_a (
        .axis_aclk     (clk),
        .axis_resetn   (rstn),
        .s_axis_tdata  (tdata_a),
        .s_axis_tkeep  (tkeep_a),
        .s_axis_tuser  (tuser_a),
        .s_axis_tvalid (tvalid_a),
        .s_axis_tready (tready_a),
        .s_axis_tlast  (tlast_a)
    );

    axis_packet_generator #(
        .AXIS_DATA_WIDTH  (DW),
        .AXIS_TUSER_WIDTH (UW),
        .DST_MAC_ADDR     (48'hA1A2A3A4A5A6),
        .SRC_MAC_ADDR     (48'hB1B2B3B4B5B6),
        .VLAN             (1'b1),
        .PRI              (3'b111),
        .VID              (12'd1),
        .SRC_PORT         (1),
        .PKT_LEN          (64),
        .GAP_CYCLES       (3),
        .START_DELAY      (5),
        .NUM_PKTS         (3)
    ) dut_b (
        .axis_aclk     (clk),
        .axis_resetn   (rstn),
        .s_axis_tdata  (tdata_b),
        .s_axis_tkeep  (tkeep_b),
        .s_axis_tuser  (tuser_b),
        .s_axis_tvalid (tvalid_b),
        .s_axis_tready (tready_b),
        .s_axis_tlast  (tlast_b)
    );

    // Reference configuration, index 0 = A, 1 = B
    int unsigned cfg_len  [2] = '{70, 64};
    int unsigned cfg_gap  [2] = '{4, 3};
    int unsigned cfg_sd   [2] = '{16, 5};
    int unsigned cfg_num  [2] = '{0, 3};
    int unsigned cfg_port [2] = '{0, 1};
    logic        cfg_vlan [2] = '{1'b0, 1'b1};
    logic [2:0]  cfg_pri  [2] = '{3'b000, 3'b111};
    logic [11:0] cfg_vid  [2] = '{12'd1, 12'd1};
    logic [47:0] cfg_dst  [2] = '{48'h111111111111, 48'hA1A2A3A4A5A6};
    logic [47:0] cfg_src  [2] = '{48'h020000000001, 48'hB1B2B3B4B5B6};

    // Reference state
    logic [7:0]  frame [2][2048];
    logic [31:0] seq [2];
    int unsigned beat [2];
    int unsigned frames [2];
    int unsigned idle_cnt [2];
    int unsigned expect_idle [2];
    bit          stalled [2];
    bit          done [2];
    logic [DW-1:0] prev_data [2];
    logic [NB-1:0] prev_keep [2];
    logic [UW-1:0] prev_user [2];
    logic          prev_last [2];

    bit          seen_a;
    int unsigned stall_left;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic build_frame(input int d);
        int unsigned n;
        int unsigned k;
        n = 0;
        for (int i = 5; i >= 0; i--) begin frame[d][n] = 8'(cfg_dst[d] >> (8*i)); n++; end
        for (int i = 5; i >= 0; i--) begin frame[d][n] = 8'(cfg_src[d] >> (8*i)); n++; end
        if (cfg_vlan[d]) begin
            frame[d][n] = 8'h81; n++;
            frame[d][n] = 8'h00; n++;
            frame[d][n] = {cfg_pri[d], 1'b0, cfg_vid[d][11:8]}; n++;
            frame[d][n] = cfg_vid[d][7:0]; n++;
        end
        frame[d][n] = 8'h88; n++;
        frame[d][n] = 8'hB5; n++;
        for (int i = 3; i >= 0; i--) begin frame[d][n] = 8'(seq[d] >> (8*i)); n++; end
        k = 0;
        while (n < cfg_len[d]) begin
            frame[d][n] = 8'(k);
            n++;
            k++;
        end
    endtask

    task automatic reset_model(input int d);
        seq[d]         = '0;
        beat[d]        = 0;
        frames[d]      = 0;
        idle_cnt[d]    = 0;
        expect_idle[d] = cfg_sd[d];
        stalled[d]     = 1'b0;
        done[d]        = 1'b0;
        build_frame(d);
    endtask

    task automatic observe(input int d, input logic v, input logic [DW-1:0] data,
                           input logic [NB-1:0] keep, input logic [UW-1:0] user,
                           input logic last, input logic rdy);
        logic [DW-1:0] e_data;
        logic [NB-1:0] e_keep;
        logic [UW-1:0] e_user;
        logic          e_last;
        int unsigned   idx;
        string         tg;
        tg = (d == 0) ? "A" : "B";
        if (!v) begin
            // tvalid may only be low between frames, never mid-frame or mid-stall
            check({tg, "_valid_drop"}, (beat[d] != 0) || stalled[d], 1'b0);
            idle_cnt[d]++;
            return;
        end
        check({tg, "_valid_after_quota"}, done[d], 1'b0);
        if (beat[d] == 0 && !stalled[d]) begin
            check({tg, "_idle_cycles"}, idle_cnt[d], expect_idle[d]);
        end
        if (stalled[d]) begin
            check({tg, "_hold_data"}, data, prev_data[d]);
            check({tg, "_hold_keep"}, keep, prev_keep[d]);
            check({tg, "_hold_user"}, user, prev_user[d]);
            check({tg, "_hold_last"}, last, prev_last[d]);
        end
        e_data = '0;
        e_keep = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            idx = beat[d] * NB + b;
            if (idx < cfg_len[d]) begin
                e_data[8*b +: 8] = frame[d][idx];
                e_keep[b]        = 1'b1;
            end
        end
        e_last = ((beat[d] + 1) * NB >= cfg_len[d]);
        e_user = '0;
        e_user[15:0]  = 16'(cfg_len[d]);
        e_user[23:16] = 8'd1 << cfg_port[d];
        check({tg, "_tdata"}, data, e_data);
        check({tg, "_tkeep"}, keep, e_keep);
        check({tg, "_tuser"}, user, e_user);
        check({tg, "_tlast"}, last, e_last);

        // Directed spot checks against literal byte values
        if (d == 0 && beat[d] == 0 && seq[d] == 0 && !stalled[d]) begin
            check("A_dst_bytes", data[47:0], 48'h111111111111);
            check("A_ethertype_bytes", data[111:96], 16'hB588);
            check("A_seq0_bytes", data[143:112], 32'h00000000);
            check("A_tuser_low", user[23:0], 24'h010046);
        end
        if (d == 0 && beat[d] == 0 && seq[d] == 1 && !stalled[d]) begin
            check("A_seq1_bytes", data[143:112], 32'h01000000);
        end
        if (d == 0 && beat[d] == 2 && !stalled[d]) begin
            check("A_final_keep", keep, 32'h0000003F);
        end
        if (d == 1 && beat[d] == 0 && seq[d] == 0 && !stalled[d]) begin
            check("B_tag_bytes", data[127:96], 32'h01E00081);
            check("B_tuser_port", user[23:16], 8'h02);
        end

        if (rdy) begin
            stalled[d] = 1'b0;
            if (e_last) begin
                seq[d]         = seq[d] + 32'd1;
                frames[d]++;
                beat[d]        = 0;
                idle_cnt[d]    = 0;
                expect_idle[d] = cfg_gap[d];
                if (cfg_num[d] != 0 && frames[d] == cfg_num[d]) done[d] = 1'b1;
                build_frame(d);
            end else begin
                beat[d]++;
            end
        end else begin
            stalled[d]   = 1'b1;
            prev_data[d] = data;
            prev_keep[d] = keep;
            prev_user[d] = user;
            prev_last[d] = last;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_A_data"}, tdata_a, '0);
        check({tag, "_A_ctl"}, {tvalid_a, tlast_a, tkeep_a, tuser_a}, '0);
        check({tag, "_B_data"}, tdata_b, '0);
        check({tag, "_B_ctl"}, {tvalid_b, tlast_b, tkeep_b, tuser_b}, '0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (!seen_a) begin
            tready_a = 1'b0;
        end else if (stall_left > 0) begin
            tready_a = 1'b0;
            stall_left--;
        end else begin
            tready_a = ($urandom_range(0, 3) != 0);
        end
        tready_b = ($urandom_range(0, 2) != 0);
        observe(0, tvalid_a, tdata_a, tkeep_a, tuser_a, tlast_a, tready_a);
        observe(1, tvalid_b, tdata_b, tkeep_b, tuser_b, tlast_b, tready_b);
        if (tvalid_a && !seen_a) begin
            // first tvalid cycle already stalled; 15 more make 16
            seen_a     = 1'b1;
            stall_left = 15;
        end
    endtask

    initial begin
        bit found;
        rstn       = 1'b0;
        tready_a   = 1'b0;
        tready_b   = 1'b0;
        seen_a     = 1'b0;
        stall_left = 0;
        reset_model(0);
        reset_model(1);

        #22;
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        for (int i = 0; i < 400; i++) cycle();
        check("B_quota_frames", frames[1], 3);
        check("A_frames_sent", frames[0] >= 3, 1'b1);

        // Land inside beat 2 of an A frame, then pulse reset between edges
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            cycle();
            if (tvalid_a && beat[0] == 1) found = 1'b1;
        end
        check("A_reset_point_found", found, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        @(posedge clk);
        #1;
        check_outputs_zero("held_reset");
        reset_model(0);
        reset_model(1);
        rstn = 1'b1;

        for (int i = 0; i < 300; i++) cycle();
        check("B_quota_frames_after_reset", frames[1], 3);
        check("A_frames_after_reset", frames[0] >= 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_packet_generator.md
# axis_packet_generator

Synthetic Ethernet frame source for switch-datapath simulation and bring-up. It drives one AXI4-Stream slave input port of the TSN switch datapath with back-to-back, parameterised frames: fixed MACs, optional 802.1Q tag with PCP, and a per-frame sequence number. Frames use NetFPGA-style side-band metadata in tuser. One instance sits in front of each datapath input port, ports 0–3 plus the CPU port 4.

## Interface
Clocking: one clock; reset is asynchronous and active-low (axis_aclk, axis_resetn).

Parameters:
- AXIS_DATA_WIDTH, 256: tdata width in bits; multiple of 64.
- AXIS_TUSER_WIDTH, 128: tuser width in bits; minimum 32.
- DST_MAC_ADDR, 48'h0: destination MAC.
- SRC_MAC_ADDR, 48'h0: source MAC.
- VLAN, 1'b0: 1 inserts an 802.1Q tag.
- PRI, 3'b000: PCP field of the tag.
- VID, 12'd1: VLAN ID.
- SRC_PORT, 0: ingress port index, 0–7.
- PKT_LEN, 64: total frame bytes excluding FCS; range 60–1514.
- GAP_CYCLES, 4: idle cycles between frames.
- START_DELAY, 16: idle cycles after reset release.
- NUM_PKTS, 0: frames to send; 0 means unlimited.

Ports:
- axis_aclk, in, 1: clock.
- axis_resetn, in, 1: async active-low reset.
- s_axis_tdata, out, AXIS_DATA_WIDTH: frame data; byte n of a beat is tdata[8n+7:8n].
- s_axis_tkeep, out, AXIS_DATA_WIDTH/8: byte enables.
- s_axis_tuser, out, AXIS_TUSER_WIDTH: metadata.
- s_axis_tvalid, out, 1: beat valid.
- s_axis_tready, in, 1: sink ready.
- s_axis_tlast, out, 1: last beat of frame.

## Operation
- Frame byte layout, wire order:
  - bytes 0–5: DST_MAC_ADDR, MSB first.
  - bytes 6–11: SRC_MAC_ADDR, MSB first.
  - If VLAN: bytes 12–13 = 0x8100; bytes 14–15 = {PRI, 1'b0, VID}.
  - Then EtherType 0x88B5.
  - Then 32-bit sequence number, MSB first.
  - Then filler bytes, where filler byte k = k[7:0] counted from the first filler byte.
- tuser layout:
  - [15:0] = PKT_LEN.
  - [23:16] = 8'b1 << SRC_PORT.
  - All other bits 0.
  - tuser is constant for every beat of a frame.
- Beats per frame = ceil(PKT_LEN / BYTES), where BYTES = AXIS_DATA_WIDTH/8.
  - Non-final beats: tkeep all ones.
  - Final beat: tkeep = (1 << r) − 1, where r = PKT_LEN mod BYTES; r = 0 means all ones.
  - Disabled bytes drive 0.
- State machine:
  - WAIT: counts START_DELAY cycles after reset, GAP_CYCLES between frames.
  - SEND: drives beats.
  - DONE: entered when NUM_PKTS ≠ 0 and that many frames have been sent; tvalid stays 0 forever.
- Transitions:
  - WAIT→SEND when the counter expires.
  - SEND→WAIT on handshake of the tlast beat.
  - SEND→DONE instead when the frame quota is reached.
- Sequence number starts at 0 and increments, wrapping at 2^32, on each tlast handshake.

## Timing
- Reset (asynchronous, while axis_resetn = 0):
  - tvalid = 0, tlast = 0; tdata, tkeep, tuser = 0.
  - State = WAIT, counters = 0, sequence = 0.
- Reset asserted mid-frame: outputs clear immediately and the frame is abandoned. After release, the next frame restarts at beat 0 with sequence 0.
- First tvalid rises START_DELAY cycles after the first rising edge with axis_resetn = 1.
- AXI-Stream rules:
  - A beat transfers on a cycle with tvalid & tready.
  - Once tvalid is asserted, tvalid, tdata, tkeep, tuser and tlast hold stable until the handshake. tvalid never depends combinationally on tready.
- Within a frame, the next beat is presented the cycle after a handshake, with no bubbles. With tready held 1, a frame of N beats takes N consecutive cycles.
- After the tlast handshake, tvalid stays 0 for exactly GAP_CYCLES cycles, then the next frame starts.
- All outputs are registered.

## Structure
- Shared package (switch-wide) holds:
  - ETH_TYPE_VLAN (0x8100) and ETH_TYPE_TEST (0x88B5).
  - tuser field offsets: LEN_LSB 0, LEN_W 16, SRC_PORT_LSB 16, SRC_PORT_W 8.
- Natural sub-module: eth_frame_beat_builder. It is combinational; given beat index and sequence number, it returns tdata and tkeep from the parameters above.
- The top level holds the FSM, counters, and output registers.

## Test plan
- Defaults, 256-bit bus, PKT_LEN 64, VLAN 0, DST 0x111111111111, tready = 1:
  - Two beats, tkeep 0xFFFFFFFF on both, tlast on beat 2.
  - Bytes 0–5 = 11 11 11 11 11 11; bytes 12–13 = 88 B5; bytes 14–17 = 00 00 00 00.
  - tuser[23:16] = 0x01, tuser[15:0] = 64.
- VLAN 1, PRI 3'b111, SRC_PORT 1:
  - Bytes 12–15 = 81 00 E0 01.
  - tuser[23:16] = 0x02.
- tready = 0 for 16 cycles after the first tvalid, then 1:
  - Beat 0 is held bit-stable for all stall cycles.
  - No beat is lost or duplicated.
- Continuous tready, GAP_CYCLES 4:
  - Exactly 4 idle cycles between tlast and the next tvalid.
  - Second frame carries sequence 1, at bytes 14–17 with no tag.
- PKT_LEN 70:
  - Three beats; final-beat tkeep = 0x0000003F.
- Reset pulse during beat 2 of a frame:
  - All outputs go to 0 asynchronously.
  - After release, the first frame carries sequence 0, START_DELAY cycles later.
